// File: rtl/msi_controller_if.sv
// Processor, cache-line, bus and snoop signals of the single-line MSI controller.
// The slave modport is the controller's view; master is the surrounding system.
interface msi_controller_if;
   logic       cpu_req_valid;
   logic       cpu_req_write;
   logic [2:0] cpu_req_address;
   logic [3:0] cpu_req_data;
   logic       cpu_req_ready;
   logic       cpu_resp_valid;
   logic [3:0] cpu_resp_data;
   logic       cpu_resp_hit;

   logic [1:0] line_state;
   logic [2:0] line_address;
   logic [3:0] line_data;
   logic       write;
   logic [1:0] state;
   logic [2:0] address;
   logic [3:0] data_in;

   logic       bus_req_valid;
   logic [1:0] bus_req_op;
   logic [2:0] bus_req_address;
   logic [3:0] bus_req_data;
   logic       bus_grant;
   logic       bus_resp_valid;
   logic [3:0] bus_resp_data;

   logic       snoop_valid;
   logic [1:0] snoop_op;
   logic [2:0] snoop_address;
   logic       snoop_flush_valid;
   logic [3:0] snoop_flush_data;

   modport slave (
      input  cpu_req_valid, cpu_req_write, cpu_req_address, cpu_req_data,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
      input  line_state, line_address, line_data,
      output write, state, address, data_in,
      output bus_req_valid, bus_req_op, bus_req_address, bus_req_data,
      input  bus_grant, bus_resp_valid, bus_resp_data,
      input  snoop_valid, snoop_op, snoop_address,
      output snoop_flush_valid, snoop_flush_data
   );

   modport master (
      output cpu_req_valid, cpu_req_write, cpu_req_address, cpu_req_data,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
      output line_state, line_address, line_data,
      input  write, state, address, data_in,
      input  bus_req_valid, bus_req_op, bus_req_address, bus_req_data,
      output bus_grant, bus_resp_valid, bus_resp_data,
      output snoop_valid, snoop_op, snoop_address,
      input  snoop_flush_valid, snoop_flush_data
   );
endinterface

// File: rtl/msi_controller.sv
// Single-line MSI snooping controller: serves CPU requests, issues bus ops and
// answers snoops, driving next-state/address/data into the external line register.
module msi_controller (
   input logic             clock,
   input logic             reset_n,
   msi_controller_if.slave bus
);
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOOKUP   = 3'd1;
   localparam logic [2:0] S_WB_REQ   = 3'd2;
   localparam logic [2:0] S_MISS_REQ = 3'd3;
   localparam logic [2:0] S_FILL     = 3'd4;
   localparam logic [2:0] S_UPDATE   = 3'd5;
   localparam logic [2:0] S_RESP     = 3'd6;

   localparam logic [1:0] L_I = 2'b00;
   localparam logic [1:0] L_S = 2'b01;
   localparam logic [1:0] L_M = 2'b10;

   localparam logic [1:0] OP_WB   = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_RDX  = 2'b10;
   localparam logic [1:0] OP_UPGR = 2'b11;

   logic [2:0] fsm_q, fsm_d;
   logic       req_wr_q, req_wr_d;
   logic [2:0] req_addr_q, req_addr_d;
   logic [3:0] req_data_q, req_data_d;
   logic [3:0] fill_q, fill_d;
   logic [1:0] op_q, op_d;
   logic [2:0] baddr_q, baddr_d;
   logic [3:0] bdata_q, bdata_d;
   logic [3:0] resp_q, resp_d;
   logic       used_q, used_d;
   logic       done_q, done_d;

   logic       line_vld, line_hit, bus_act, granted;
   logic       snp_wr, snp_flush;
   logic [1:0] snp_st;
   logic       fsm_wr;
   logic [1:0] fsm_st;
   logic [2:0] fsm_addr;
   logic [3:0] fsm_data;

   assign line_vld = (bus.line_state == L_S) || (bus.line_state == L_M);
   assign line_hit = line_vld && (bus.line_address == req_addr_q);
   assign bus_act  = ((fsm_q == S_WB_REQ) || (fsm_q == S_MISS_REQ)) && !done_q;
   // done_q remembers a grant whose line write was pre-empted by a snoop
   assign granted  = done_q || (bus_act && bus.bus_grant);

   always_comb begin
      snp_wr    = 1'b0;
      snp_flush = 1'b0;
      snp_st    = L_I;
      if (reset_n && bus.snoop_valid && line_vld && (bus.snoop_address == bus.line_address)) begin
         case (bus.snoop_op)
            OP_RD: if (bus.line_state == L_M) begin
               snp_wr    = 1'b1;
               snp_flush = 1'b1;
               snp_st    = L_S;
            end
            OP_RDX, OP_UPGR: begin
               snp_wr    = 1'b1;
               snp_flush = (bus.line_state == L_M);
               snp_st    = L_I;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      req_wr_d   = req_wr_q;
      req_addr_d = req_addr_q;
      req_data_d = req_data_q;
      fill_d     = fill_q;
      op_d       = op_q;
      baddr_d    = baddr_q;
      bdata_d    = bdata_q;
      resp_d     = resp_q;
      used_d     = used_q;
      done_d     = done_q;
      fsm_wr     = 1'b0;
      fsm_st     = L_I;
      fsm_addr   = 3'd0;
      fsm_data   = 4'd0;
      case (fsm_q)
         S_IDLE: if (bus.cpu_req_valid) begin
            req_wr_d   = bus.cpu_req_write;
            req_addr_d = bus.cpu_req_address;
            req_data_d = bus.cpu_req_data;
            resp_d     = 4'd0;
            used_d     = 1'b0;
            done_d     = 1'b0;
            fsm_d      = S_LOOKUP;
         end
         // A snoop write this cycle holds LOOKUP so it re-evaluates the updated line
         S_LOOKUP: if (!snp_wr) begin
            if (line_hit && !req_wr_q) begin
               resp_d = bus.line_data;
               fsm_d  = S_RESP;
            end else if (line_hit && (bus.line_state == L_M)) begin
               fsm_wr   = 1'b1;
               fsm_st   = L_M;
               fsm_addr = req_addr_q;
               fsm_data = req_data_q;
               fsm_d    = S_RESP;
            end else if (line_hit) begin
               op_d    = OP_UPGR;
               baddr_d = req_addr_q;
               bdata_d = 4'd0;
               fsm_d   = S_MISS_REQ;
            end else if (bus.line_state == L_M) begin
               op_d    = OP_WB;
               baddr_d = bus.line_address;
               bdata_d = bus.line_data;
               fsm_d   = S_WB_REQ;
            end else begin
               op_d    = req_wr_q ? OP_RDX : OP_RD;
               baddr_d = req_addr_q;
               bdata_d = 4'd0;
               fsm_d   = S_MISS_REQ;
            end
         end
         S_WB_REQ: if (granted) begin
            used_d = 1'b1;
            if (snp_wr) begin
               done_d = 1'b1;
            end else begin
               fsm_wr   = 1'b1;
               fsm_st   = L_I;
               fsm_addr = bus.line_address;
               fsm_data = bus.line_data;
               done_d   = 1'b0;
               op_d     = req_wr_q ? OP_RDX : OP_RD;
               baddr_d  = req_addr_q;
               bdata_d  = 4'd0;
               fsm_d    = S_MISS_REQ;
            end
         end else if (snp_wr) begin
            fsm_d = S_LOOKUP;
         end
         S_MISS_REQ: if (granted) begin
            used_d = 1'b1;
            if (op_q != OP_UPGR) begin
               done_d = 1'b0;
               fsm_d  = S_FILL;
            end else if (snp_wr) begin
               done_d = 1'b1;
            end else begin
               fsm_wr   = 1'b1;
               fsm_st   = L_M;
               fsm_addr = req_addr_q;
               fsm_data = req_data_q;
               done_d   = 1'b0;
               resp_d   = 4'd0;
               fsm_d    = S_RESP;
            end
         end else if (snp_wr) begin
            fsm_d = S_LOOKUP;
         end
         S_FILL: if (bus.bus_resp_valid) begin
            fill_d = bus.bus_resp_data;
            fsm_d  = S_UPDATE;
         end
         S_UPDATE: if (!snp_wr) begin
            fsm_wr   = 1'b1;
            fsm_st   = req_wr_q ? L_M : L_S;
            fsm_addr = req_addr_q;
            fsm_data = req_wr_q ? req_data_q : fill_q;
            resp_d   = req_wr_q ? 4'd0 : fill_q;
            fsm_d    = S_RESP;
         end
         S_RESP:  fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q      <= S_IDLE;
         req_wr_q   <= 1'b0;
         req_addr_q <= 3'd0;
         req_data_q <= 4'd0;
         fill_q     <= 4'd0;
         op_q       <= 2'd0;
         baddr_q    <= 3'd0;
         bdata_q    <= 4'd0;
         resp_q     <= 4'd0;
         used_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         req_wr_q   <= req_wr_d;
         req_addr_q <= req_addr_d;
         req_data_q <= req_data_d;
         fill_q     <= fill_d;
         op_q       <= op_d;
         baddr_q    <= baddr_d;
         bdata_q    <= bdata_d;
         resp_q     <= resp_d;
         used_q     <= used_d;
         done_q     <= done_d;
      end
   end

   assign bus.cpu_req_ready     = (fsm_q == S_IDLE);
   assign bus.cpu_resp_valid    = (fsm_q == S_RESP);
   assign bus.cpu_resp_data     = (fsm_q == S_RESP) ? resp_q : 4'd0;
   assign bus.cpu_resp_hit      = (fsm_q == S_RESP) && !used_q;

   // Snoop writes own the line port; FSM writes are only raised when no snoop writes
   assign bus.write             = snp_wr || fsm_wr;
   assign bus.state             = snp_wr ? snp_st : fsm_st;
   assign bus.address           = snp_wr ? bus.line_address : fsm_addr;
   assign bus.data_in           = snp_wr ? bus.line_data : fsm_data;

   assign bus.bus_req_valid     = bus_act;
   assign bus.bus_req_op        = bus_act ? op_q : 2'd0;
   assign bus.bus_req_address   = bus_act ? baddr_q : 3'd0;
   assign bus.bus_req_data      = bus_act ? bdata_q : 4'd0;

   assign bus.snoop_flush_valid = snp_flush;
   assign bus.snoop_flush_data  = snp_flush ? bus.line_data : 4'd0;
endmodule

// File: tb/tb_msi_controller.sv
// Directed bench for msi_controller with a behavioural cache-line register.
module tb_msi_controller;
   localparam logic [1:0] L_I = 2'b00, L_S = 2'b01, L_M = 2'b10;
   localparam logic [1:0] OP_WB = 2'b00, OP_RD = 2'b01, OP_RDX = 2'b10, OP_UPGR = 2'b11;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int errs = 0;
   int checks = 0;
   logic [31:0] e32;
   logic [9:0]  e10;
   logic [8:0]  e9;
   logic [5:0]  e6;
   logic [4:0]  e5;

   logic [1:0] ln_st;
   logic [2:0] ln_a;
   logic [3:0] ln_d;

   msi_controller_if ifc();
   msi_controller dut (.clock(clock), .reset_n(reset_n), .bus(ifc));

   always #5 clock = ~clock;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ln_st <= 2'd0; ln_a <= 3'd0; ln_d <= 4'd0;
      end else if (ifc.write) begin
         ln_st <= ifc.state; ln_a <= ifc.address; ln_d <= ifc.data_in;
      end
   end
   assign ifc.line_state   = ln_st;
   assign ifc.line_address = ln_a;
   assign ifc.line_data    = ln_d;

   function automatic logic [9:0] line_wr();
      return {ifc.write, ifc.state, ifc.address, ifc.data_in};
   endfunction
   function automatic logic [9:0] bus_rq();
      return {ifc.bus_req_valid, ifc.bus_req_op, ifc.bus_req_address, ifc.bus_req_data};
   endfunction
   function automatic logic [5:0] resp();
      return {ifc.cpu_resp_valid, ifc.cpu_resp_data, ifc.cpu_resp_hit};
   endfunction
   function automatic logic [4:0] flush();
      return {ifc.snoop_flush_valid, ifc.snoop_flush_data};
   endfunction
   function automatic logic [31:0] outs();
      return {ifc.cpu_req_ready, resp(), line_wr(), bus_rq(), flush()};
   endfunction

   task automatic nxt();
      @(posedge clock); #1;
   endtask
   task automatic smp();
      @(negedge clock);
   endtask
   task automatic do_req(input logic wr, input logic [2:0] a, input logic [3:0] d);
      ifc.cpu_req_valid = 1'b1; ifc.cpu_req_write = wr;
      ifc.cpu_req_address = a; ifc.cpu_req_data = d;
      nxt();
      ifc.cpu_req_valid = 1'b0;
   endtask
   task automatic grant_fill(input logic [3:0] d);
      ifc.bus_grant = 1'b1; nxt(); ifc.bus_grant = 1'b0;
      ifc.bus_resp_valid = 1'b1; ifc.bus_resp_data = d; nxt(); ifc.bus_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      smp();
      e32 = {1'b1, 31'd0};
      if (outs() !== e32) begin errs++; $display("FAIL reset_outs got=%h exp=%h", outs(), e32); end
      checks++;
      nxt(); reset_n = 1'b1; nxt();
   endtask

   task automatic test_read_miss();
      do_req(1'b0, 3'd3, 4'h0);
      nxt(); smp();
      e10 = {1'b1, OP_RD, 3'd3, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL rdmiss_req got=%h exp=%h", bus_rq(), e10); end
      checks++;
      nxt(); smp();
      if (bus_rq() !== e10) begin errs++; $display("FAIL rdmiss_hold got=%h exp=%h", bus_rq(), e10); end
      checks++;
      ifc.bus_grant = 1'b1; nxt(); ifc.bus_grant = 1'b0;
      smp();
      if (bus_rq() !== 10'd0) begin errs++; $display("FAIL rdmiss_drop got=%h exp=0", bus_rq()); end
      checks++;
      ifc.bus_resp_valid = 1'b1; ifc.bus_resp_data = 4'hA; nxt(); ifc.bus_resp_valid = 1'b0;
      smp();
      e10 = {1'b1, L_S, 3'd3, 4'hA};
      if (line_wr() !== e10) begin errs++; $display("FAIL rdmiss_update got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'hA, 1'b0};
      if (resp() !== e6) begin errs++; $display("FAIL rdmiss_resp got=%h exp=%h", resp(), e6); end
      checks++;
      e9 = {L_S, 3'd3, 4'hA};
      if ({ln_st, ln_a, ln_d} !== e9) begin errs++; $display("FAIL rdmiss_line got=%h exp=%h", {ln_st, ln_a, ln_d}, e9); end
      checks++;
      nxt();
   endtask

   task automatic test_upgrade();
      do_req(1'b1, 3'd3, 4'h5);
      nxt(); smp();
      e10 = {1'b1, OP_UPGR, 3'd3, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL upgr_req got=%h exp=%h", bus_rq(), e10); end
      checks++;
      ifc.bus_grant = 1'b1; #1;
      e10 = {1'b1, L_M, 3'd3, 4'h5};
      if (line_wr() !== e10) begin errs++; $display("FAIL upgr_write got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.bus_grant = 1'b0; smp();
      e6 = {1'b1, 4'h0, 1'b0};
      if (resp() !== e6) begin errs++; $display("FAIL upgr_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
   endtask

   task automatic test_hits();
      do_req(1'b0, 3'd3, 4'h0);
      smp();
      if (bus_rq() !== 10'd0) begin errs++; $display("FAIL rdhit_nobus got=%h exp=0", bus_rq()); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'h5, 1'b1};
      if (resp() !== e6) begin errs++; $display("FAIL rdhit_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
      do_req(1'b1, 3'd3, 4'h5);
      smp();
      e10 = {1'b1, L_M, 3'd3, 4'h5};
      if (line_wr() !== e10) begin errs++; $display("FAIL wrhit_write got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'h0, 1'b1};
      if (resp() !== e6) begin errs++; $display("FAIL wrhit_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
   endtask

   task automatic test_writeback();
      do_req(1'b0, 3'd6, 4'h0);
      nxt(); smp();
      e10 = {1'b1, OP_WB, 3'd3, 4'h5};
      if (bus_rq() !== e10) begin errs++; $display("FAIL wb_req got=%h exp=%h", bus_rq(), e10); end
      checks++;
      ifc.bus_grant = 1'b1; #1;
      e10 = {1'b1, L_I, 3'd3, 4'h5};
      if (line_wr() !== e10) begin errs++; $display("FAIL wb_inval got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.bus_grant = 1'b0; smp();
      e10 = {1'b1, OP_RD, 3'd6, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL wb_then_rd got=%h exp=%h", bus_rq(), e10); end
      checks++;
      nxt(); grant_fill(4'hC); smp();
      e10 = {1'b1, L_S, 3'd6, 4'hC};
      if (line_wr() !== e10) begin errs++; $display("FAIL wb_update got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'hC, 1'b0};
      if (resp() !== e6) begin errs++; $display("FAIL wb_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
   endtask

   task automatic test_write_miss();
      do_req(1'b1, 3'd2, 4'h9);
      nxt(); smp();
      e10 = {1'b1, OP_RDX, 3'd2, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL wrmiss_req got=%h exp=%h", bus_rq(), e10); end
      checks++;
      nxt(); grant_fill(4'hF); smp();
      e10 = {1'b1, L_M, 3'd2, 4'h9};
      if (line_wr() !== e10) begin errs++; $display("FAIL wrmiss_update got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); nxt();
   endtask

   task automatic test_snoop();
      ifc.snoop_valid = 1'b1; ifc.snoop_op = OP_RD; ifc.snoop_address = 3'd2;
      smp();
      e5 = {1'b1, 4'h9};
      if (flush() !== e5) begin errs++; $display("FAIL snp_rd_flush got=%h exp=%h", flush(), e5); end
      checks++;
      e10 = {1'b1, L_S, 3'd2, 4'h9};
      if (line_wr() !== e10) begin errs++; $display("FAIL snp_rd_line got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.snoop_op = OP_RDX; smp();
      if (flush() !== 5'd0) begin errs++; $display("FAIL snp_rdx_noflush got=%h exp=0", flush()); end
      checks++;
      e10 = {1'b1, L_I, 3'd2, 4'h9};
      if (line_wr() !== e10) begin errs++; $display("FAIL snp_rdx_line got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.snoop_valid = 1'b0;
   endtask

   task automatic test_snoop_pending();
      do_req(1'b0, 3'd4, 4'h0);
      nxt(); grant_fill(4'h1); nxt(); nxt();
      do_req(1'b1, 3'd4, 4'h3);
      nxt(); smp();
      e10 = {1'b1, OP_UPGR, 3'd4, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL pend_upgr got=%h exp=%h", bus_rq(), e10); end
      checks++;
      ifc.snoop_valid = 1'b1; ifc.snoop_op = OP_UPGR; ifc.snoop_address = 3'd4; #1;
      e10 = {1'b1, L_I, 3'd4, 4'h1};
      if (line_wr() !== e10) begin errs++; $display("FAIL pend_snp_inval got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.snoop_valid = 1'b0; smp();
      if (bus_rq() !== 10'd0) begin errs++; $display("FAIL pend_dropped got=%h exp=0", bus_rq()); end
      checks++;
      nxt(); smp();
      e10 = {1'b1, OP_RDX, 3'd4, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL pend_reissue got=%h exp=%h", bus_rq(), e10); end
      checks++;
      nxt(); grant_fill(4'h8); smp();
      e10 = {1'b1, L_M, 3'd4, 4'h3};
      if (line_wr() !== e10) begin errs++; $display("FAIL pend_update got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'h0, 1'b0};
      if (resp() !== e6) begin errs++; $display("FAIL pend_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
   endtask

   task automatic test_snoop_lookup();
      do_req(1'b1, 3'd4, 4'h6);
      ifc.snoop_valid = 1'b1; ifc.snoop_op = OP_RD; ifc.snoop_address = 3'd4;
      smp();
      e10 = {1'b1, L_S, 3'd4, 4'h3};
      if (line_wr() !== e10) begin errs++; $display("FAIL lk_snoop_wins got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.snoop_valid = 1'b0; smp();
      if ({line_wr(), bus_rq()} !== 20'd0) begin errs++; $display("FAIL lk_reeval got=%h exp=0", {line_wr(), bus_rq()}); end
      checks++;
      nxt(); smp();
      e10 = {1'b1, OP_UPGR, 3'd4, 4'h0};
      if (bus_rq() !== e10) begin errs++; $display("FAIL lk_upgr got=%h exp=%h", bus_rq(), e10); end
      checks++;
      ifc.bus_grant = 1'b1; #1;
      e10 = {1'b1, L_M, 3'd4, 4'h6};
      if (line_wr() !== e10) begin errs++; $display("FAIL lk_upgr_write got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.bus_grant = 1'b0; nxt();
   endtask

   task automatic test_snoop_update();
      ifc.snoop_valid = 1'b1; ifc.snoop_op = OP_RD; ifc.snoop_address = 3'd4;
      smp();
      e5 = {1'b1, 4'h6};
      if (flush() !== e5) begin errs++; $display("FAIL upd_pre_flush got=%h exp=%h", flush(), e5); end
      checks++;
      nxt(); ifc.snoop_valid = 1'b0;
      do_req(1'b0, 3'd5, 4'h0);
      nxt(); grant_fill(4'h2);
      ifc.snoop_valid = 1'b1; ifc.snoop_op = OP_RDX; ifc.snoop_address = 3'd4;
      smp();
      e10 = {1'b1, L_I, 3'd4, 4'h6};
      if (line_wr() !== e10) begin errs++; $display("FAIL upd_snoop_wins got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); ifc.snoop_valid = 1'b0; smp();
      e10 = {1'b1, L_S, 3'd5, 4'h2};
      if (line_wr() !== e10) begin errs++; $display("FAIL upd_stalled_wr got=%h exp=%h", line_wr(), e10); end
      checks++;
      nxt(); smp();
      e6 = {1'b1, 4'h2, 1'b0};
      if (resp() !== e6) begin errs++; $display("FAIL upd_resp got=%h exp=%h", resp(), e6); end
      checks++;
      nxt();
   endtask

   task automatic test_reset_fill();
      do_req(1'b0, 3'd7, 4'h0);
      nxt();
      ifc.bus_grant = 1'b1; nxt(); ifc.bus_grant = 1'b0;
      smp();
      reset_n = 1'b0; #1;
      e32 = {1'b1, 31'd0};
      if (outs() !== e32) begin errs++; $display("FAIL rst_fill_outs got=%h exp=%h", outs(), e32); end
      checks++;
      if ({ln_st, ln_a, ln_d} !== 9'd0) begin errs++; $display("FAIL rst_fill_line got=%h exp=0", {ln_st, ln_a, ln_d}); end
      checks++;
      nxt(); reset_n = 1'b1; nxt(); smp();
      if (outs() !== e32) begin errs++; $display("FAIL rst_after_idle got=%h exp=%h", outs(), e32); end
      checks++;
   endtask

   initial begin
      ifc.cpu_req_valid = 1'b0; ifc.cpu_req_write = 1'b0;
      ifc.cpu_req_address = 3'd0; ifc.cpu_req_data = 4'd0;
      ifc.bus_grant = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.bus_resp_data = 4'd0;
      ifc.snoop_valid = 1'b0; ifc.snoop_op = 2'd0; ifc.snoop_address = 3'd0;
      test_reset();
      test_read_miss();
      test_upgrade();
      test_hits();
      test_writeback();
      test_write_miss();
      test_snoop();
      test_snoop_pending();
      test_snoop_lookup();
      test_snoop_update();
      test_reset_fill();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/msi_controller.md
# msi_controller

Single-line MSI snooping coherence controller that sits directly upstream of the `cache` line register. It accepts processor read and write requests and snooped bus transactions. It decides the next line state, address and data, and drives them into the line's `write/state/address/data_in` inputs. It also issues bus requests (BusRd, BusRdX, BusUpgr, WriteBack) and flushes modified data when a snoop hits.

## Interface

Parameters: none. Widths are fixed: address 3 bits, data 4 bits, state 2 bits.

State encoding: 00 Invalid, 01 Shared, 10 Modified. The value 11 is treated as Invalid.

Bus op encoding: 00 WriteBack, 01 BusRd, 10 BusRdX, 11 BusUpgr.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req_valid`  in  1  processor request present.
- `cpu_req_write`  in  1  1 = write, 0 = read.
- `cpu_req_address`  in  3  request address.
- `cpu_req_data`  in  4  write data.
- `cpu_req_ready`  out  1  high only in IDLE; a request is accepted on `valid & ready`.
- `cpu_resp_valid`  out  1  one-cycle completion pulse.
- `cpu_resp_data`  out  4  read data; 0 for writes.
- `cpu_resp_hit`  out  1  1 if completed without a bus transaction.
- `line_state`  in  2  `current_state` from the cache line.
- `line_address`  in  3  `current_address` from the cache line.
- `line_data`  in  4  `current_data` from the cache line.
- `write`  out  1  cache line write enable.
- `state`  out  2  next line state.
- `address`  out  3  next line address.
- `data_in`  out  4  next line data.
- `bus_req_valid`  out  1  bus request; held until `bus_grant`.
- `bus_req_op`  out  2  bus op.
- `bus_req_address`  out  3  bus request address.
- `bus_req_data`  out  4  WriteBack data.
- `bus_grant`  in  1  one-cycle grant of the pending request.
- `bus_resp_valid`  in  1  fill data valid (BusRd/BusRdX only).
- `bus_resp_data`  in  4  fill data.
- `snoop_valid`  in  1  snooped transaction from another cache.
- `snoop_op`  in  2  snooped op.
- `snoop_address`  in  3  snooped address.
- `snoop_flush_valid`  out  1  one-cycle flush pulse.
- `snoop_flush_data`  out  4  flushed Modified data.

## Operation

- FSM states: IDLE, LOOKUP, WB_REQ, MISS_REQ, FILL, UPDATE, RESP.
- Accept: the request is registered into a request buffer (write, address, data); IDLE→LOOKUP.
- LOOKUP: hit = (`line_address == req address`) & state ≠ Invalid.
  - Read hit (S or M) → RESP with `line_data`, hit = 1.
  - Write hit M → `write` = 1 (M, addr, req data) → RESP, hit = 1.
  - Write hit S → MISS_REQ with BusUpgr.
  - Miss with victim in M → WB_REQ (op 00, victim address and data).
  - Miss otherwise → MISS_REQ with BusRd (read) or BusRdX (write).
- WB_REQ: on grant, write the line Invalid, then → MISS_REQ (BusRd or BusRdX).
- MISS_REQ:
  - BusUpgr: on grant, write (M, addr, req data) → RESP.
  - BusRd/BusRdX: on grant → FILL.
- FILL: on `bus_resp_valid`, capture `bus_resp_data` into the fill buffer → UPDATE.
- UPDATE:
  - Read: write (S, addr, fill data); response data = fill data.
  - Write: write (M, addr, req data); the whole 4-bit line is overwritten.
  - Then → RESP.
- RESP: `cpu_resp_valid` = 1 for one cycle; hit = 0 if any bus op was used; → IDLE.
- Snoop hit = `snoop_valid` & (`snoop_address == line_address`) & state ≠ Invalid.
  - BusRd on M: flush, line → S.
  - BusRd on S: no action.
  - BusRdX on M: flush, line → I.
  - BusRdX or BusUpgr on S: line → I.
  - WriteBack snoops: ignored.
- Snoop priority: a snoop line write owns the `write` port that cycle. Any FSM line write due that cycle (LOOKUP, UPDATE, grant-completion) is stalled by one cycle. LOOKUP re-evaluates using the updated line.
- Snoop during a pending request: if a snoop writes the line while in WB_REQ or MISS_REQ before grant, drop `bus_req_valid` and return to LOOKUP. Example: an S line invalidated before a BusUpgr grant becomes a BusRdX.

## Timing

- Reset (async assert): FSM = IDLE. Buffers cleared to 0. All outputs 0 except `cpu_req_ready` = 1.
- Request accepted in cycle N. LOOKUP occurs in N+1.
- Hit latency:
  - Read hit: `cpu_resp_valid` in N+2.
  - Write hit M: `write` in N+1, resp in N+2.
- Bus requests:
  - `bus_req_valid`, op, address and data stay stable from state entry until the grant cycle.
  - `bus_req_valid` drops the cycle after grant.
- Fill path: `bus_resp_valid` in cycle F → line write in F+1 (UPDATE) → resp in F+2.
- Flush timing: `snoop_flush_valid` and the line write occur in the same cycle as `snoop_valid`, i.e. combinational from snoop inputs and registered line outputs.
- `write` is never asserted twice for one cause. `write` is never asserted while `reset_n` = 0.

## Test plan

- Reset, then read addr 3 (line I) → BusRd addr 3 → grant → `bus_resp_data`=0xA → line (S,3,0xA), resp data 0xA, hit 0.
- Line (S,3,0xA), write addr 3 data 0x5 → BusUpgr → grant → line (M,3,0x5), resp hit 0; then read addr 3 → resp 0x5 in N+2, hit 1, no bus activity.
- Line (M,3,0x5), read addr 6 → WriteBack addr 3 data 0x5 → grant → line I → BusRd addr 6 → fill 0xC → line (S,6,0xC).
- Line (M,2,0x9), snoop BusRd addr 2 → same-cycle flush 0x9, line → S; snoop BusRdX addr 2 → line → I, no flush.
- Line (S,4,0x1), write addr 4 waiting for grant; snoop BusUpgr addr 4 → line I, request dropped, reissued as BusRdX addr 4.
- Snoop hit in the same cycle as a write-hit LOOKUP → snoop write wins, FSM write occurs one cycle later on the updated state; `reset_n` low mid-FILL → IDLE immediately, all outputs 0.
